// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_arb_pkg
// Purpose  : Shared definitions for the FIFO write arbiter.
//            - Default constants for requester count, data width and the
//              length of the FIFO-clear phase.
//            - Controller state encoding.
//            - Helper for index/counter widths that stay legal when N = 1.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

    localparam int C_N_REQ       = 4;
    localparam int C_DW          = 8;
    localparam int C_INIT_CYCLES = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLR  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // Width needed to hold values 0..n-1. Never returns 0.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_arbiter_if
// Purpose  : Bus bundle between the FIFO write arbiter and its environment.
// Ports    : init, request[N_REQ], DATA_IN[N_REQ*DW], FULL, EMPTY, rd_req
//            (towards arbiter); grant[N_REQ], WRITE, DATA_OUT[DW], read,
//            fifo_clr (from arbiter); grant_cnt[N_REQ*8] only when
//            FIFO_ARB_STATS_EN is defined.
//            Modport slave = arbiter side, master = environment side.
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = C_N_REQ,
    parameter int DW    = C_DW
);
    logic                  init;
    logic [N_REQ-1:0]      request;
    logic [N_REQ*DW-1:0]   DATA_IN;
    logic                  FULL;
    logic                  EMPTY;
    logic                  rd_req;
    logic [N_REQ-1:0]      grant;
    logic                  WRITE;
    logic [DW-1:0]         DATA_OUT;
    logic                  read;
    logic                  fifo_clr;
`ifdef FIFO_ARB_STATS_EN
    logic [N_REQ*8-1:0]    grant_cnt;

    modport slave (
        input  init, request, DATA_IN, FULL, EMPTY, rd_req,
        output grant, WRITE, DATA_OUT, read, fifo_clr, grant_cnt
    );
    modport master (
        output init, request, DATA_IN, FULL, EMPTY, rd_req,
        input  grant, WRITE, DATA_OUT, read, fifo_clr, grant_cnt
    );
`else
    modport slave (
        input  init, request, DATA_IN, FULL, EMPTY, rd_req,
        output grant, WRITE, DATA_OUT, read, fifo_clr
    );
    modport master (
        output init, request, DATA_IN, FULL, EMPTY, rd_req,
        input  grant, WRITE, DATA_OUT, read, fifo_clr
    );
`endif
endinterface
`default_nettype wire

// File: rtl/fifo_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin picker. Scans the request vector
//            starting at index ptr_i, wrapping from N-1 to 0, and returns
//            the first asserted request as a one-hot vector.
// Ports    : req_i[N]  - request vector
//            ptr_i[PW] - index with highest priority (must be < N)
//            win_o[N]  - one-hot winner, all zero when no request
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  win_o
);

    always_comb begin
        logic          found;
        logic [PW-1:0] idx;
        win_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int off = 0; off < N; off++) begin
            idx = PW'((int'(ptr_i) + off) % N);
            if (!found && req_i[idx]) begin
                win_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_arbiter
// Purpose  : Round-robin write arbiter in front of a FIFO with a timed
//            clear phase. IDLE -> CLR (fifo_clr for INIT_CYCLES cycles)
//            -> RUN while init is high; init low returns to IDLE at once.
//            In RUN one requester is granted per cycle when FULL is low,
//            and a read strobe is issued for rd_req & !EMPTY. All strobes
//            are registered (one-cycle latency).
// Ports    : CLK   - clock, rising edge
//            RESET - asynchronous, active-low reset
//            bus   - fifo_arbiter_if.slave (see interface header)
// Option   : FIFO_ARB_STATS_EN adds bus.grant_cnt, one 8-bit saturating
//            grant counter per requester, cleared in CLR and by reset.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ       = C_N_REQ,
    parameter int DW          = C_DW,
    parameter int INIT_CYCLES = C_INIT_CYCLES
) (
    input  logic           CLK,
    input  logic           RESET,
    fifo_arbiter_if.slave  bus
);

    localparam int PW = idx_w(N_REQ);
    localparam int CW = idx_w(INIT_CYCLES);

    state_t           state_q, state_d;
    logic [CW-1:0]    clr_cnt_q, clr_cnt_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             write_q, write_d;
    logic [DW-1:0]    data_q, data_d;
    logic             read_q, read_d;
    logic             clr_q, clr_d;

    logic             run_en;
    logic [N_REQ-1:0] pick_req;
    logic [N_REQ-1:0] win;
    logic [PW-1:0]    win_idx;
    logic [DW-1:0]    win_data;

    // Arbitration only happens when staying in RUN with room downstream,
    // so a stalled or leaving cycle never moves the pointer.
    assign run_en   = (state_q == ST_RUN) && (state_d == ST_RUN);
    assign pick_req = (run_en && !bus.FULL) ? bus.request : '0;

    rr_pick #(
        .N  (N_REQ),
        .PW (PW)
    ) u_pick (
        .req_i (pick_req),
        .ptr_i (ptr_q),
        .win_o (win)
    );

    // Winner index and its data slice.
    always_comb begin
        win_idx  = '0;
        win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win[i]) begin
                win_idx  = PW'(i);
                win_data = bus.DATA_IN[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.init) begin
                    state_d   = ST_CLR;
                    clr_cnt_d = '0;
                end
            end
            ST_CLR: begin
                if (!bus.init) begin
                    state_d = ST_IDLE;
                end else if (clr_cnt_q == CW'(INIT_CYCLES - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    clr_cnt_d = clr_cnt_q + CW'(1);
                end
            end
            ST_RUN: begin
                if (!bus.init) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        grant_d = win;
        write_d = |win;
        read_d  = run_en && bus.rd_req && !bus.EMPTY;
        clr_d   = (state_d == ST_CLR);

        // Data is forced to zero outside RUN and held on idle RUN cycles.
        if (!run_en) begin
            data_d = '0;
        end else if (write_d) begin
            data_d = win_data;
        end else begin
            data_d = data_q;
        end

        ptr_d = ptr_q;
        if (write_d) begin
            ptr_d = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + PW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= ST_IDLE;
            clr_cnt_q <= '0;
            ptr_q     <= '0;
            grant_q   <= '0;
            write_q   <= 1'b0;
            data_q    <= '0;
            read_q    <= 1'b0;
            clr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            write_q   <= write_d;
            data_q    <= data_d;
            read_q    <= read_d;
            clr_q     <= clr_d;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.WRITE    = write_q;
    assign bus.DATA_OUT = data_q;
    assign bus.read     = read_q;
    assign bus.fifo_clr = clr_q;

`ifdef FIFO_ARB_STATS_EN
    logic [N_REQ*8-1:0] grant_cnt_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            grant_cnt_q <= '0;
        end else if (state_d == ST_CLR) begin
            grant_cnt_q <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (grant_d[i] && (grant_cnt_q[i*8 +: 8] != 8'hFF)) begin
                    grant_cnt_q[i*8 +: 8] <= grant_cnt_q[i*8 +: 8] + 8'd1;
                end
            end
        end
    end

    assign bus.grant_cnt = grant_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_arbiter
// Purpose  : Directed self-checking bench for fifo_arbiter (N_REQ=4, DW=8,
//            INIT_CYCLES=4). Expected outputs are queued when inputs are
//            driven and compared one clock later. Stats counter checks are
//            compiled in when FIFO_ARB_STATS_EN is defined.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_arbiter;
    import fifo_arb_pkg::*;

    logic CLK = 1'b0;
    logic RESET;

    always #5 CLK = ~CLK;

    fifo_arbiter_if #(.N_REQ(4), .DW(8)) bus();

    fifo_arbiter #(
        .N_REQ       (4),
        .DW          (8),
        .INIT_CYCLES (4)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0] g;
        logic       w;
        logic [7:0] d;
        logic       r;
        logic       c;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        check({tag, ".grant"}, 32'(bus.grant),    32'h0);
        check({tag, ".write"}, 32'(bus.WRITE),    32'h0);
        check({tag, ".data"},  32'(bus.DATA_OUT), 32'h0);
        check({tag, ".read"},  32'(bus.read),     32'h0);
        check({tag, ".clr"},   32'(bus.fifo_clr), 32'h0);
    endtask

    // Drive one cycle of inputs, queue the outputs expected after the next
    // rising edge, then compare them 1 time unit after that edge.
    task automatic cyc(input string tag, input logic [3:0] req, input logic full,
                       input logic empty, input logic rd, input logic [3:0] eg,
                       input logic ew, input logic [7:0] ed, input logic er,
                       input logic ec);
        exp_t e;
        bus.request = req;
        bus.FULL    = full;
        bus.EMPTY   = empty;
        bus.rd_req  = rd;
        sb_q.push_back('{g: eg, w: ew, d: ed, r: er, c: ec});
        @(posedge CLK);
        #1;
        e = sb_q.pop_front();
        check({tag, ".grant"}, 32'(bus.grant),    32'(e.g));
        check({tag, ".write"}, 32'(bus.WRITE),    32'(e.w));
        check({tag, ".data"},  32'(bus.DATA_OUT), 32'(e.d));
        check({tag, ".read"},  32'(bus.read),     32'(e.r));
        check({tag, ".clr"},   32'(bus.fifo_clr), 32'(e.c));
    endtask

    initial begin
        RESET       = 1'b0;
        bus.init    = 1'b0;
        bus.request = 4'b0000;
        bus.DATA_IN = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        bus.FULL    = 1'b0;
        bus.EMPTY   = 1'b1;
        bus.rd_req  = 1'b0;

        #2;
        chk_zero("reset");
        #2;
        RESET    = 1'b1;
        bus.init = 1'b1;

        // Clear phase: requests present but ignored.
        for (int k = 0; k < 4; k++)
            cyc("clr", 4'b1111, 0, 1, 0, 4'b0000, 0, 8'h00, 0, 1);
        cyc("run_entry", 4'b1111, 0, 1, 0, 4'b0000, 0, 8'h00, 0, 0);

        // Round-robin across all four requesters.
        cyc("rr0", 4'b1111, 0, 1, 0, 4'b0001, 1, 8'hAA, 0, 0);
        cyc("rr1", 4'b1111, 0, 1, 0, 4'b0010, 1, 8'hBB, 0, 0);
        cyc("rr2", 4'b1111, 0, 1, 0, 4'b0100, 1, 8'hCC, 0, 0);
        cyc("rr3", 4'b1111, 0, 1, 0, 4'b1000, 1, 8'hDD, 0, 0);
        cyc("rr4", 4'b1111, 0, 1, 0, 4'b0001, 1, 8'hAA, 0, 0);

        // Wrap-around from last grant 3.
        cyc("last3", 4'b1000, 0, 1, 0, 4'b1000, 1, 8'hDD, 0, 0);
        cyc("wrap0", 4'b1001, 0, 1, 0, 4'b0001, 1, 8'hAA, 0, 0);
        cyc("wrap1", 4'b1001, 0, 1, 0, 4'b1000, 1, 8'hDD, 0, 0);
        cyc("wrap2", 4'b1001, 0, 1, 0, 4'b0001, 1, 8'hAA, 0, 0);

        // No request: no write, data held.
        cyc("noreq", 4'b0000, 0, 1, 0, 4'b0000, 0, 8'hAA, 0, 0);

        // FULL stall, then resume at requester 1.
        for (int k = 0; k < 3; k++)
            cyc("full", 4'b0110, 1, 1, 0, 4'b0000, 0, 8'hAA, 0, 0);
        cyc("resume0", 4'b0110, 0, 1, 0, 4'b0010, 1, 8'hBB, 0, 0);
        cyc("resume1", 4'b0110, 0, 1, 0, 4'b0100, 1, 8'hCC, 0, 0);
        cyc("resume2", 4'b0110, 0, 1, 0, 4'b0010, 1, 8'hBB, 0, 0);

        // Request withdrawn before the sampling edge.
        bus.request = 4'b0100;
        #2;
        cyc("dropped", 4'b0000, 0, 1, 0, 4'b0000, 0, 8'hBB, 0, 0);

        // Reads alongside writes, EMPTY toggling.
        cyc("rdw0", 4'b0001, 0, 0, 1, 4'b0001, 1, 8'hAA, 1, 0);
        cyc("rdw1", 4'b0001, 0, 1, 1, 4'b0001, 1, 8'hAA, 0, 0);
        cyc("rdw2", 4'b0001, 0, 0, 1, 4'b0001, 1, 8'hAA, 1, 0);
        cyc("rdnone", 4'b0000, 0, 0, 0, 4'b0000, 0, 8'hAA, 0, 0);

        // init low in RUN -> IDLE, then an aborted CLR restarts in full.
        bus.init = 1'b0;
        cyc("idle", 4'b1111, 0, 0, 1, 4'b0000, 0, 8'h00, 0, 0);
        bus.init = 1'b1;
        cyc("clrA0", 4'b1111, 0, 0, 1, 4'b0000, 0, 8'h00, 0, 1);
        cyc("clrA1", 4'b1111, 0, 0, 1, 4'b0000, 0, 8'h00, 0, 1);
        bus.init = 1'b0;
        cyc("abort", 4'b1111, 0, 0, 1, 4'b0000, 0, 8'h00, 0, 0);
        bus.init = 1'b1;
        for (int k = 0; k < 4; k++)
            cyc("clrB", 4'b1111, 0, 0, 1, 4'b0000, 0, 8'h00, 0, 1);
        cyc("run2", 4'b0100, 0, 0, 0, 4'b0000, 0, 8'h00, 0, 0);
        cyc("g2", 4'b0100, 0, 1, 0, 4'b0100, 1, 8'hCC, 0, 0);

        // Asynchronous reset mid-RUN; pointer must return to requester 0.
        bus.request = 4'b1111;
        bus.rd_req  = 1'b1;
        bus.EMPTY   = 1'b0;
        #3;
        RESET = 1'b0;
        #1;
        chk_zero("async_rst");
        cyc("rst_hold", 4'b1111, 0, 0, 1, 4'b0000, 0, 8'h00, 0, 0);
        RESET = 1'b1;
        for (int k = 0; k < 4; k++)
            cyc("clrR", 4'b1111, 0, 0, 1, 4'b0000, 0, 8'h00, 0, 1);
        cyc("runR", 4'b1111, 0, 0, 1, 4'b0000, 0, 8'h00, 0, 0);
        cyc("prio0", 4'b1111, 0, 0, 1, 4'b0001, 1, 8'hAA, 1, 0);
        cyc("prio1", 4'b1111, 0, 0, 1, 4'b0010, 1, 8'hBB, 1, 0);

`ifdef FIFO_ARB_STATS_EN
        for (int k = 0; k < 300; k++)
            cyc("stat", 4'b0100, 0, 1, 0, 4'b0100, 1, 8'hCC, 0, 0);
        check("cnt2_sat", 32'(bus.grant_cnt[23:16]), 32'd255);
        check("cnt0",     32'(bus.grant_cnt[7:0]),   32'd1);
        bus.init = 1'b0;
        cyc("st_idle", 4'b0000, 0, 1, 0, 4'b0000, 0, 8'h00, 0, 0);
        bus.init = 1'b1;
        for (int k = 0; k < 4; k++)
            cyc("st_clr", 4'b0000, 0, 1, 0, 4'b0000, 0, 8'h00, 0, 1);
        cyc("st_run", 4'b0000, 0, 1, 0, 4'b0000, 0, 8'h00, 0, 0);
        check("cnt2_clr", 32'(bus.grant_cnt[23:16]), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_arbiter.md
FIFO_ARBITER -- requirements
Module: fifo_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of write requesters.
REQ-002 SHALL have parameter DW, default 8, data width per requester.
REQ-003 SHALL have parameter INIT_CYCLES, default 4, number of cycles the FIFO-clear phase lasts.
REQ-004 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port init  input  1  level enable; high starts the clear phase, then normal operation.
REQ-007 SHALL have port request  input  N_REQ  per-requester write request, bit i = requester i.
REQ-008 SHALL have port DATA_IN  input  N_REQ*DW  packed write data; slice i belongs to requester i.
REQ-009 SHALL have port FULL  input  1  downstream FIFO full flag.
REQ-010 SHALL have port EMPTY  input  1  downstream FIFO empty flag.
REQ-011 SHALL have port rd_req  input  1  consumer read request.
REQ-012 SHALL have port grant  output  N_REQ  one-hot grant, registered.
REQ-013 SHALL have port WRITE  output  1  FIFO write strobe, registered.
REQ-014 SHALL have port DATA_OUT  output  DW  FIFO write data, registered.
REQ-015 SHALL have port read  output  1  FIFO read strobe, registered.
REQ-016 SHALL have port fifo_clr  output  1  FIFO synchronous-clear strobe, registered.

Function
REQ-017 SHALL implement states IDLE, CLR and RUN.
REQ-018 IDLE SHALL move to CLR when init=1.
REQ-019 CLR SHALL hold fifo_clr=1 for exactly INIT_CYCLES cycles, then move to RUN.
REQ-020 SHALL go directly to IDLE from CLR or RUN when init=0 at a clock edge.
- A CLR aborted this way SHALL restart from its first cycle on the next init=1.
REQ-021 SHALL produce grant, WRITE, DATA_OUT and read only in RUN; all are 0 in IDLE and CLR.
REQ-022 In RUN with FULL=0 and request nonzero, SHALL grant exactly one requester, round-robin.
- Search starts at (last granted index + 1) mod N_REQ and wraps past N_REQ-1 to 0.
REQ-023 Grant latency SHALL be one cycle.
- request sampled at edge k produces grant, WRITE=1 and DATA_OUT = DATA_IN slice of the winner, all valid after edge k+1.
REQ-024 SHALL NOT grant when FULL=1.
- WRITE=0 and the round-robin pointer is unchanged.
REQ-025 Only requests asserted at the sampling edge SHALL be eligible; a request dropped before that edge is not granted.
REQ-026 When FULL=0 and request=0, SHALL drive WRITE=0 and grant=0 and leave the pointer unchanged.
REQ-027 In RUN, read SHALL be rd_req AND NOT EMPTY, registered with one-cycle latency.
REQ-028 read and WRITE SHALL be allowed in the same cycle.
REQ-029 DATA_OUT SHALL hold its last value when WRITE=0.

Reset
REQ-030 RESET=0 SHALL asynchronously force state IDLE, grant=0, WRITE=0, DATA_OUT=0, read=0 and fifo_clr=0.
REQ-031 RESET=0 SHALL also set the round-robin pointer so requester 0 has first priority.
REQ-032 Reset asserted mid-CLR or mid-RUN SHALL discard all progress.
- No write or read strobe SHALL appear after reset is released until RUN is re-entered.

Configuration
REQ-033 With macro FIFO_ARB_STATS_EN defined, SHALL add output grant_cnt (N_REQ*8 bits).
- One 8-bit saturating counter per requester, incremented on each grant.
- Held at 255 once saturated; cleared in CLR and by reset.
REQ-034 Without FIFO_ARB_STATS_EN, grant_cnt and its logic SHALL be absent.

Structure
REQ-035 SHALL place the state enumeration and the default constants N_REQ, DW and INIT_CYCLES in shared package fifo_arb_pkg.
REQ-036 SHALL implement round-robin selection in sub-module rr_pick.
- Inputs: request vector and pointer; output: one-hot winner.
- Purely combinational.

Verification
REQ-037 Scenario: RESET=0 at t=0, released at t=4 with init=1 -> fifo_clr=1 for exactly 4 cycles, then RUN; all outputs 0 before that.
REQ-038 Scenario: request=4'b1111, DATA_IN slices 0..3 = AA, BB, CC, DD, FULL=0 -> grants 0001, 0010, 0100, 1000, 0001 on consecutive cycles; DATA_OUT AA, BB, CC, DD, AA.
REQ-039 Scenario: request=4'b1001 with last grant 3 -> next grant 0001, then 1000 (wrap-around).
REQ-040 Scenario: FULL=1 for 3 cycles with request=4'b0110 -> WRITE=0 for those 3 cycles; after FULL=0, grant resumes at the requester that was next before the stall.
REQ-041 Scenario: rd_req=1 with EMPTY toggling 0,1,0, and a write in the same cycles -> read=1,0,1 one cycle later, and WRITE unaffected.
REQ-042 Scenario (FIFO_ARB_STATS_EN): 300 grants to requester 2 -> grant_cnt slice 2 = 255; init cycled low then high -> slice 2 = 0 after CLR.
